// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the four-channel KEY debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    KD_RELEASED     = 2'd0,
    KD_PRESS_WAIT   = 2'd1,
    KD_PRESSED      = 2'd2,
    KD_RELEASE_WAIT = 2'd3
  } kd_state_e;

  localparam int unsigned NUM_KEYS      = 4;
  localparam int unsigned KEY_TURN_DONE = 0;
  localparam int unsigned KEY_NEW_GAME  = 1;
  localparam int unsigned KEY_RESIGN    = 2;
  localparam int unsigned KEY_DRAW      = 3;

  // One-hot of the lowest set bit; lower key index has priority.
  function automatic logic [NUM_KEYS-1:0] lowest_one(input logic [NUM_KEYS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One KEY channel: 2-flop synchroniser, stability counter and debounce FSM.
// With KEY_LOCKOUT_EN an idle flag is exported for the lockout arbiter.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
`ifdef KEY_LOCKOUT_EN
  output logic idle,
`endif
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic             key_s;
  kd_state_e        state;
  logic [CNT_W-1:0] cnt;

  // sync holds pressed-sense (inverted KEY), so the reset value 0 means released.
  assign key_s = sync[1];

`ifdef KEY_LOCKOUT_EN
  assign idle = (state == KD_RELEASED);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      state <= KD_RELEASED;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], ~key};
      pulse <= 1'b0;
      case (state)
        KD_RELEASED: begin
          if (key_s) begin
            state <= KD_PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        KD_PRESS_WAIT: begin
          if (!key_s) begin
            state <= KD_RELEASED;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state <= KD_PRESSED;
            cnt   <= '0;
            pulse <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        KD_PRESSED: begin
          if (!key_s) begin
            state <= KD_RELEASE_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        KD_RELEASE_WAIT: begin
          if (key_s) begin
            state <= KD_PRESSED;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state <= KD_RELEASED;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= KD_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Four-channel push-button conditioner (turn done, new game, resign, draw).
// Define KEY_LOCKOUT_EN to allow only one accepted press until all keys release.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] KEY,
  output logic [3:0] key_pulse,
  output logic [3:0] key_level
);

  logic [NUM_KEYS-1:0] raw_pulse;
`ifdef KEY_LOCKOUT_EN
  logic [NUM_KEYS-1:0] idle;
  logic                lock;
`endif

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .key  (KEY[i]),
`ifdef KEY_LOCKOUT_EN
      .idle (idle[i]),
`endif
      .pulse(raw_pulse[i]),
      .level(key_level[i])
    );
  end

`ifdef KEY_LOCKOUT_EN
  // Gating uses only registered terms, so the pulse keeps the channel latency
  // and there is still no path from KEY to the outputs.
  always_comb begin
    key_pulse = '0;
    if (!lock) key_pulse = lowest_one(raw_pulse);
  end

  always_ff @(posedge clk) begin
    if (reset)           lock <= 1'b0;
    else if (|key_pulse) lock <= 1'b1;
    else if (&idle)      lock <= 1'b0;
  end
`else
  assign key_pulse = raw_pulse;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts
// outputs per cycle; a monitor compares them against the DUT.
module tb_key_debounce;

  localparam int unsigned D     = 4;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [3:0] pulse;
    logic [3:0] level;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [3:0] key_pulse;
  logic [3:0] key_level;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  exp_t        sb[$];

  key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .KEY      (KEY),
    .key_pulse(key_pulse),
    .key_level(key_level)
  );

  always #5 clk = ~clk;

  // Reference model: pressed samples reach the decision logic two edges late;
  // the debounced level flips after D+1 consecutive samples disagreeing with it.
  logic [3:0] m_s1, m_s2, m_level;
  int unsigned m_run [4];
  logic        m_lock, m_prev_any, m_prev_idle;

  task automatic model_step(input logic [3:0] k, input logic r);
    exp_t       e;
    logic [3:0] sample, raw;
    logic       new_lock;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_lock = 1'b0; m_prev_any = 1'b0; m_prev_idle = 1'b1;
      e.pulse = '0;
    end else begin
      new_lock = m_prev_any ? 1'b1 : (m_prev_idle ? 1'b0 : m_lock);
      sample = m_s2;
      m_s2 = m_s1;
      m_s1 = ~k;
      raw = '0;
      for (int i = 0; i < 4; i++) begin
        if (sample[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_level[i] = ~m_level[i];
            m_run[i] = 0;
            if (m_level[i]) raw[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`ifdef KEY_LOCKOUT_EN
      e.pulse = new_lock ? 4'b0 : (raw & (~raw + 4'd1));
`else
      e.pulse = raw;
`endif
      m_lock = new_lock;
      m_prev_any = |e.pulse;
      m_prev_idle = 1'b1;
      for (int i = 0; i < 4; i++)
        if (m_level[i] || m_run[i] != 0) m_prev_idle = 1'b0;
    end
    e.level = m_level;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] k, input logic r);
    @(negedge clk);
    KEY = k;
    reset = r;
    @(posedge clk);
    model_step(k, r);
  endtask

  task automatic hold(input logic [3:0] k, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(k, 1'b0);
  endtask

  // Monitor: pops one expectation per presented cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (key_pulse !== e.pulse) begin
          miscompares++;
          $display("FAIL key_pulse t=%0t got=%b exp=%b", $time, key_pulse, e.pulse);
        end
        vectors++;
        if (key_level !== e.level) begin
          miscompares++;
          $display("FAIL key_level t=%0t got=%b exp=%b", $time, key_level, e.level);
        end
      end
    end
  end

  initial begin
    logic [3:0] k;
    int unsigned guard;
    KEY = 4'hF;
    reset = 1'b1;
    hold(4'hF, 0);
    for (int i = 0; i < 3; i++) drive(4'hF, 1'b1);
    // Plain press/hold/release on KEY[0]
    hold(4'b1110, 12);
    hold(4'hF, 10);
    // Bounce on KEY[1]: low 3, high 1, low held
    hold(4'b1101, 3);
    hold(4'hF, 1);
    hold(4'b1101, 12);
    hold(4'hF, 10);
    // Release bounce on KEY[2] while held
    hold(4'b1011, 10);
    hold(4'hF, 2);
    hold(4'b1011, 10);
    hold(4'hF, 10);
    // Reset during PRESS_WAIT on KEY[3], key held throughout
    hold(4'b0111, 4);
    for (int i = 0; i < 2; i++) drive(4'b0111, 1'b1);
    hold(4'b0111, 12);
    hold(4'hF, 10);
    // Simultaneous press on KEY[1]/KEY[2], release, then KEY[2] alone
    hold(4'b1001, 12);
    hold(4'hF, 12);
    hold(4'b1011, 12);
    hold(4'hF, 12);
    // Randomised toggling with occasional resets
    k = 4'hF;
    for (int unsigned c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) k[i] = ~k[i];
      drive(k, ($urandom_range(0, 399) == 0));
    end
    hold(4'hF, 12);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
